rr_dispatcher: RTL and testbench

- Round-robin dispatch stage that sits directly upstream of the generic `demux`.
- Buffers a single valid/ready input stream in a small FIFO.
- Picks the next enabled consumer in round-robin order and holds the offer until that consumer accepts it.
- `data_o` and `sel_o` drive the demux `data_i` and `sel_i`. The one-hot `valid_o` qualifies which demux output carries live data.

---
 rtl/rr_dispatcher.sv | 135 +++++++++++++
 tb/tb_rr_dispatcher.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_dispatcher.sv
// Round-robin dispatch stage: buffers one valid/ready stream in a small FIFO and
// offers each head entry to the next enabled consumer, holding the offer until it is accepted.
module rr_dispatcher #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumOutputs = 8,
    parameter int unsigned Depth      = 2,
    localparam int unsigned SelWidth  = (NumOutputs > 1) ? $clog2(NumOutputs) : 1,
    localparam int unsigned LvlWidth  = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DataWidth-1:0]  data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [NumOutputs-1:0] en_i,
    output logic [DataWidth-1:0]  data_o,
    output logic [SelWidth-1:0]   sel_o,
    output logic [NumOutputs-1:0] valid_o,
    input  logic [NumOutputs-1:0] ready_i,
    output logic [LvlWidth-1:0]   level_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned SelW1    = SelWidth + 1;
    localparam logic [LvlWidth-1:0] DepthLvl = LvlWidth'(Depth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [SelWidth-1:0] LastSel  = SelWidth'(NumOutputs - 1);
    localparam logic [SelWidth:0]   NumOut   = SelW1'(NumOutputs);

    typedef enum logic {IDLE, OFFER} state_e;

    state_e                state_q, state_d;
    logic [SelWidth-1:0]   sel_q, sel_d;
    logic [SelWidth-1:0]   next_ptr_q, next_ptr_d;
    logic [LvlWidth-1:0]   level_q, level_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0]  mem_q [Depth];

    logic                  push;
    logic                  pop;
    logic [SelWidth-1:0]   wrap_ptr;
    logic [SelWidth:0]     pick_now;
    logic [SelWidth:0]     pick_next;

    // Returns {found, index} of the first enabled consumer at or after start, wrapping.
    function automatic logic [SelWidth:0] pick_target(input logic [NumOutputs-1:0] en,
                                                      input logic [SelWidth-1:0]   start);
        logic                found;
        logic [SelWidth-1:0] idx;
        logic [SelWidth:0]   cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NumOutputs; i++) begin
            cand = {1'b0, start} + SelW1'(i);
            if (cand >= NumOut) cand = cand - NumOut;
            if (!found && en[cand[SelWidth-1:0]]) begin
                found = 1'b1;
                idx   = cand[SelWidth-1:0];
            end
        end
        return {found, idx};
    endfunction

    assign ready_o = (level_q < DepthLvl);
    assign level_o = level_q;
    assign sel_o   = sel_q;
    assign data_o  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign valid_o = (state_q == OFFER) ? (NumOutputs'(1) << sel_q) : '0;

    always_comb begin
        push      = valid_i && ready_o;
        pop       = (state_q == OFFER) && ready_i[sel_q];
        wrap_ptr  = (sel_q == LastSel) ? '0 : sel_q + SelWidth'(1);
        pick_now  = pick_target(en_i, next_ptr_q);
        pick_next = pick_target(en_i, wrap_ptr);

        level_d    = level_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        state_d    = state_q;
        sel_d      = sel_q;
        next_ptr_d = next_ptr_q;

        if (push && !pop)      level_d = level_q + LvlWidth'(1);
        else if (!push && pop) level_d = level_q - LvlWidth'(1);
        if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);

        case (state_q)
            IDLE: begin
                // Registered level only: an entry pushed this edge is offered next cycle.
                if (level_q != '0 && pick_now[SelWidth]) begin
                    sel_d   = pick_now[SelWidth-1:0];
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (pop) begin
                    next_ptr_d = wrap_ptr;
                    if ((level_q > LvlWidth'(1) || push) && pick_next[SelWidth]) begin
                        sel_d = pick_next[SelWidth-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            next_ptr_q <= '0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            next_ptr_q <= next_ptr_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; data_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed bench for rr_dispatcher: round-robin order, enable masking, offer hold,
// FIFO backpressure, idle-without-enable and asynchronous reset mid-offer.
module tb_rr_dispatcher;

    localparam int DW = 32;
    localparam int NO = 8;
    localparam int DP = 2;
    localparam int SW = 3;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [NO-1:0] en_i;
    logic [DW-1:0] data_o;
    logic [SW-1:0] sel_o;
    logic [NO-1:0] valid_o;
    logic [NO-1:0] ready_i;
    logic [LW-1:0] level_o;

    int nvec = 0;
    int nerr = 0;
    logic [DW-1:0] src[$];

    rr_dispatcher #(.DataWidth(DW), .NumOutputs(NO), .Depth(DP)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .en_i   (en_i),
        .data_o (data_o),
        .sel_o  (sel_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .level_o(level_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [NO-1:0] v,
                             input logic [SW-1:0] s, input logic [DW-1:0] d);
        check_eq({tag, " valid"}, 64'(valid_o), 64'(v));
        check_eq({tag, " sel"},   64'(sel_o),   64'(s));
        check_eq({tag, " data"},  64'(data_o),  64'(d));
    endtask

    task automatic drive();
        valid_i = (src.size() != 0);
        data_i  = (src.size() != 0) ? src[0] : '0;
    endtask

    // Advance one clock; the source queue advances only when the handshake fired.
    task automatic tick();
        logic fire;
        drive();
        fire = valid_i && ready_o;
        @(posedge clk);
        #1;
        if (fire) void'(src.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src.delete();
        valid_i = 1'b0;
        data_i  = '0;
        en_i    = '0;
        ready_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        do_reset();
        check_eq("rst level", 64'(level_o), 0);
        check_eq("rst ready", 64'(ready_o), 1);
        check_out("rst", 8'h00, 3'd0, 32'h0);

        // Full enable, all consumers ready: 0,1,2,3 back to back.
        en_i = 8'hFF; ready_i = 8'hFF;
        src = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
        tick();
        check_eq("t1 lat valid", 64'(valid_o), 0);
        check_eq("t1 lat level", 64'(level_o), 1);
        tick();
        check_out("t1 a", 8'h01, 3'd0, 32'hA000_0001);
        check_eq("t1 full level", 64'(level_o), 2);
        check_eq("t1 full ready", 64'(ready_o), 0);
        tick(); check_out("t1 b", 8'h02, 3'd1, 32'hB000_0002);
        tick(); check_out("t1 c", 8'h04, 3'd2, 32'hC000_0003);
        tick(); check_out("t1 d", 8'h08, 3'd3, 32'hD000_0004);
        tick();
        check_eq("t1 end valid", 64'(valid_o), 0);
        check_eq("t1 end level", 64'(level_o), 0);

        // Sparse enable with wrap: 2,5,7,2.
        do_reset();
        en_i = 8'b1010_0100; ready_i = 8'hFF;
        src = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
        tick();
        tick(); check_out("t2 w0", 8'h04, 3'd2, 32'h1111_0000);
        check_eq("t2 mask0", 64'(valid_o & ~en_i), 0);
        tick(); check_out("t2 w1", 8'h20, 3'd5, 32'h2222_0000);
        check_eq("t2 mask1", 64'(valid_o & ~en_i), 0);
        tick(); check_out("t2 w2", 8'h80, 3'd7, 32'h3333_0000);
        check_eq("t2 mask2", 64'(valid_o & ~en_i), 0);
        tick(); check_out("t2 w3", 8'h04, 3'd2, 32'h4444_0000);
        tick(); check_eq("t2 end valid", 64'(valid_o), 0);

        // Offer held on target 3 despite other ready bits and en_i[3] dropping.
        do_reset();
        en_i = 8'h08; ready_i = 8'h10;
        src = '{32'hCAFE_0003, 32'hBEEF_0004};
        tick();
        tick();
        check_out("t3 hold0", 8'h08, 3'd3, 32'hCAFE_0003);
        check_eq("t3 hold0 level", 64'(level_o), 2);
        en_i = 8'h10;
        for (int i = 1; i < 5; i++) begin
            tick();
            check_out($sformatf("t3 hold%0d", i), 8'h08, 3'd3, 32'hCAFE_0003);
            check_eq($sformatf("t3 hold%0d level", i), 64'(level_o), 2);
        end
        ready_i = 8'h08;
        tick();
        check_out("t3 next", 8'h10, 3'd4, 32'hBEEF_0004);
        check_eq("t3 next level", 64'(level_o), 1);
        ready_i = 8'h10;
        tick();
        check_eq("t3 end valid", 64'(valid_o), 0);
        check_eq("t3 end level", 64'(level_o), 0);

        // Backpressure: third word waits at the input while the FIFO is full.
        do_reset();
        en_i = 8'hFF; ready_i = 8'h00;
        src = '{32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
        tick();
        check_eq("t4 l1", 64'(level_o), 1);
        check_eq("t4 r1", 64'(ready_o), 1);
        tick();
        check_eq("t4 l2", 64'(level_o), 2);
        check_eq("t4 r2", 64'(ready_o), 0);
        check_out("t4 p", 8'h01, 3'd0, 32'h0000_00A1);
        tick();
        check_eq("t4 l2b", 64'(level_o), 2);
        check_eq("t4 r2b", 64'(ready_o), 0);
        ready_i = 8'hFF;
        tick();
        check_eq("t4 rel level", 64'(level_o), 1);
        check_eq("t4 rel ready", 64'(ready_o), 1);
        check_out("t4 q", 8'h02, 3'd1, 32'h0000_00A2);
        tick();
        check_eq("t4 pp level", 64'(level_o), 1);
        check_out("t4 r", 8'h04, 3'd2, 32'h0000_00A3);
        tick();
        check_eq("t4 end level", 64'(level_o), 0);
        check_eq("t4 end valid", 64'(valid_o), 0);

        // No enabled consumer: entry waits in IDLE until en_i[6] rises.
        do_reset();
        en_i = 8'h00; ready_i = 8'hFF;
        src = '{32'h5A5A_0006};
        tick();
        tick();
        check_eq("t5 idle valid", 64'(valid_o), 0);
        check_eq("t5 idle level", 64'(level_o), 1);
        tick();
        check_eq("t5 idle valid2", 64'(valid_o), 0);
        en_i = 8'h40;
        tick();
        check_out("t5 go", 8'h40, 3'd6, 32'h5A5A_0006);
        tick();
        check_eq("t5 end valid", 64'(valid_o), 0);
        check_eq("t5 end level", 64'(level_o), 0);

        // Asynchronous reset mid-offer with two entries buffered.
        do_reset();
        en_i = 8'hFF; ready_i = 8'h00;
        src = '{32'h7777_0001, 32'h7777_0002};
        tick();
        tick();
        check_out("t6 pre", 8'h01, 3'd0, 32'h7777_0001);
        check_eq("t6 pre level", 64'(level_o), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t6 async", 8'h00, 3'd0, 32'h0);
        check_eq("t6 async level", 64'(level_o), 0);
        check_eq("t6 async ready", 64'(ready_o), 1);
        src.delete();
        valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check_eq("t6 post valid", 64'(valid_o), 0);
        check_eq("t6 post level", 64'(level_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
